instr_fetch_queue: RTL

//  Fetch stage of the 5-stage RV64 pipeline, directly upstream of the IF/ID register.
//  - Issues in-order word fetches to instruction memory.
//  - Buffers returned {pc, instr} pairs in a small prefetch FIFO.
//  - Presents the FIFO head to IF/ID with a valid/ready handshake. Ready = IF/ID write enable (low on load-use stall).
//  - A taken-branch redirect flushes the FIFO and discards responses still in flight.

---
 rtl/riscv_pipe_pkg.sv | 24 ++
 rtl/instr_fetch_queue_if.sv | 31 +++
 rtl/ifq_fifo.sv | 50 +++++
 rtl/instr_fetch_queue.sv | 112 +++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the RV64 fetch stage.
package riscv_pipe_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

   // One prefetched instruction together with the PC it was fetched from
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   // 32-bit add that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: imem request/response, branch redirect and IF/ID handshake.
interface instr_fetch_queue_if;
   import riscv_pipe_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic            if_ready;
   logic [ILEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;

   // Fetch-queue side
   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc, if_ready
   );

   // Memory / pipeline side
   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc, if_ready
   );

endinterface

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO with clear; DEPTH must be a power of two.
module ifq_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers and occupancy; clear wins over push/pop
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage, not reset: only entries below count are ever observed
   always_ff @(posedge clk) begin
      if (rst_n && !clear && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// RV64 fetch stage: in-order imem fetch, prefetch FIFO, redirect flush.
// Optional IFQ_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module instr_fetch_queue
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_queue_if.master bus
`ifdef IFQ_PERF_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_flushed
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   outstanding;
   logic            q_full, q_empty, t_full, t_empty;
   fetch_entry_t    q_din, q_dout;
   logic [XLEN-1:0] tag_pc;
   logic [SW-1:0]   in_use;
   logic            req_fire, q_push, q_pop, t_push, t_pop;

   // Credit: buffered entries plus in-flight requests never exceed DEPTH
   assign in_use             = SW'(q_count) + SW'(outstanding);
   assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (in_use < SW'(DEPTH));
   assign bus.imem_req_addr  = fetch_pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign t_push = req_fire && !t_full;
   assign t_pop  = bus.imem_rsp_valid && !t_empty;
   assign q_push = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt == '0) && !q_full;
   assign q_pop  = !q_empty && bus.if_ready && !bus.redirect_valid;
   assign q_din  = '{pc: tag_pc, instr: bus.imem_rsp_data};

   assign bus.if_valid = !q_empty;
   assign bus.if_instr = q_empty ? '0 : q_dout.instr;
   assign bus.if_pc    = q_empty ? '0 : q_dout.pc;

   // Prefetch buffer of {pc, instr} presented to IF/ID
   ifq_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.redirect_valid),
      .push  (q_push),
      .pop   (q_pop),
      .din   (q_din),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   // PC tags of in-flight requests; survives redirects so stale responses still pop their tag
   ifq_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tags (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (1'b0),
      .push  (t_push),
      .pop   (t_pop),
      .din   (fetch_pc),
      .dout  (tag_pc),
      .full  (t_full),
      .empty (t_empty),
      .count (outstanding)
   );

   // Next fetch address: redirect target (word aligned) or sequential
   always_ff @(posedge clk) begin
      if (!rst_n)                  fetch_pc <= RESET_PC;
      else if (bus.redirect_valid) fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      else if (req_fire)           fetch_pc <= fetch_pc + XLEN'(4);
   end

   // Number of stale responses still to discard after a redirect
   always_ff @(posedge clk) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (bus.redirect_valid)
         drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
      else if (bus.imem_rsp_valid && drop_cnt != '0)
         drop_cnt <= drop_cnt - CW'(1);
   end

`ifdef IFQ_PERF_EN
   logic [31:0] flush_inc;

   assign flush_inc = bus.redirect_valid
                    ? 32'(q_count) + 32'(bus.imem_rsp_valid)
                    : 32'(bus.imem_rsp_valid && drop_cnt != '0);

   // Saturating counts of delivered and flushed instructions
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         perf_fetched <= sat_add32(perf_fetched, 32'(q_pop));
         perf_flushed <= sat_add32(perf_flushed, flush_inc);
      end
   end
`endif

endmodule
